// File: rtl/alu_exec_seq_pkg.sv
// alu_exec_seq_pkg: shared widths, opcodes and state encoding for the ALU execution stage
package alu_exec_seq_pkg;
    localparam int DATA_W    = 8;
    localparam int NREGS     = 4;
    localparam int IDX_W     = 2;
    localparam int MUL_STEPS = 8;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_LDI  = 5'b10001;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
endpackage

// File: rtl/alu_regfile_4x8.sv
// alu_regfile_4x8: 4x8 register file, two asynchronous read ports, one synchronous write port
module alu_regfile_4x8
    import alu_exec_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [IDX_W-1:0]  ra1,
    input  logic [IDX_W-1:0]  ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: command-driven execution stage feeding an external 8-bit combinational ALU
module alu_exec_seq
    import alu_exec_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_rd,
    input  logic [IDX_W-1:0]  cmd_rs1,
    input  logic [IDX_W-1:0]  cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [2:0]        flags
);
    state_t state, state_d;
    logic [3:0]        op_q;
    logic [IDX_W-1:0]  rd_q, rs1_q, rs2_q, ra1, ra2;
    logic [DATA_W-1:0] res_q, acc, mcand, mplier, acc_d, rd1, rd2;
    logic [2:0]        znv_q, flags_q;
    logic [3:0]        cnt;
    logic              err_q, accept, we;

    assign accept = cmd_valid && cmd_ready;
    assign we     = state == S_RESP && rsp_ready && !err_q;
    assign acc_d  = mplier[0] ? alu_result : acc;
    // In IDLE the read ports follow the incoming command so MUL can seed its operands on accept.
    assign ra1    = state == S_IDLE ? cmd_rs1 : rs1_q;
    assign ra2    = state == S_IDLE ? cmd_rs2 : rs2_q;

    alu_regfile_4x8 u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (rd_q),
        .wd   (res_q),
        .ra1  (ra1),
        .ra2  (ra2),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = !cmd_op[4] ? S_EXEC : cmd_op == OP_MUL ? S_MUL : S_RESP;
            end
            S_EXEC: begin
                alu_a   = rd1;
                alu_b   = rd2;
                alu_op  = op_q;
                state_d = S_RESP;
            end
            S_MUL: begin
                alu_a   = acc;
                alu_b   = mcand;
                alu_op  = ALU_ADD;
                state_d = cnt == 4'd1 ? S_RESP : S_MUL;
            end
            S_RESP:  state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            znv_q   <= '0;
            err_q   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            flags_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q   <= cmd_op[3:0];
                rd_q   <= cmd_rd;
                rs1_q  <= cmd_rs1;
                rs2_q  <= cmd_rs2;
                err_q  <= cmd_op[4] && cmd_op != OP_MUL && cmd_op != OP_LDI;
                acc    <= '0;
                mcand  <= rd1;
                mplier <= rd2;
                cnt    <= 4'(MUL_STEPS);
                res_q  <= cmd_op == OP_LDI ? cmd_imm : '0;
                znv_q  <= cmd_op == OP_LDI ? {cmd_imm == '0, cmd_imm[DATA_W-1], 1'b0} : 3'b000;
            end
            if (state == S_EXEC) begin
                res_q <= alu_result;
                znv_q <= {alu_zero, alu_neg, alu_ovf};
            end
            if (state == S_MUL) begin
                acc    <= acc_d;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    res_q <= acc_d;
                    znv_q <= {acc_d == '0, acc_d[DATA_W-1], 1'b0};
                end
            end
            if (we) flags_q <= znv_q;
        end
    end

    assign rsp_valid = state == S_RESP;
    assign rsp_data  = res_q;
    assign rsp_err   = err_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: table-driven scoreboard bench for alu_exec_seq with a behavioural ALU model
module tb_alu_exec_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [4:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [7:0] cmd_imm = '0;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic       alu_zero, alu_neg, alu_ovf;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [7:0] rsp_data;
    logic [2:0] flags;

    localparam logic [4:0] LDI = 5'h11, MUL = 5'h10, ADD = 5'h00, BSA = 5'h01, EQ = 5'h05, RSV = 5'h12;

    typedef struct {
        logic [4:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm, data;
        logic       err;
        logic [2:0] flg;
        int         lat;
    } vec_t;
    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [2:0] flg;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[20];
    int   total = 0, bad = 0;

    alu_exec_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flags(flags)
    );

    always #5 clk = ~clk;

    // ALU: 0 ADD, 1 B-A, 2 AND, 3 OR, 4 XOR, 5 EQ, others return 0
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_result = alu_a + alu_b;
                alu_ovf    = alu_a[7] == alu_b[7] && alu_result[7] != alu_a[7];
            end
            4'd1: begin
                alu_result = alu_b - alu_a;
                alu_ovf    = alu_b[7] != alu_a[7] && alu_result[7] != alu_b[7];
            end
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = {7'd0, alu_a == alu_b};
            default: alu_result = '0;
        endcase
        alu_zero = alu_result == '0;
        alu_neg  = alu_result[7];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] rd, rs1, rs2, input logic [7:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        exp_t e;
        int   n;
        @(negedge clk);
        drive(v.op, v.rd, v.rs1, v.rs2, v.imm);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        @(posedge clk);
        sb.push_back('{v.data, v.err, v.flg, v.lat});
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(n);
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        if (!e.err) check({tag, "_data"}, int'(rsp_data), int'(e.data));
        check({tag, "_err"}, int'(rsp_err), int'(e.err));
        @(negedge clk);
        check({tag, "_flags"}, int'(flags), int'(e.flg));
        check({tag, "_rsp_drop"}, int'(rsp_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        tbl = '{
            '{LDI, 2'd1, 2'd0, 2'd0, 8'h0A, 8'h0A, 1'b0, 3'b000, 1},
            '{LDI, 2'd2, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 3'b000, 1},
            '{ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h0F, 1'b0, 3'b000, 2},
            '{BSA, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFB, 1'b0, 3'b010, 2},
            '{LDI, 2'd0, 2'd0, 2'd0, 8'h7F, 8'h7F, 1'b0, 3'b000, 1},
            '{LDI, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 3'b000, 1},
            '{ADD, 2'd2, 2'd0, 2'd1, 8'h00, 8'h80, 1'b0, 3'b011, 2},
            '{EQ,  2'd3, 2'd2, 2'd2, 8'h00, 8'h01, 1'b0, 3'b000, 2},
            '{LDI, 2'd1, 2'd0, 2'd0, 8'h0D, 8'h0D, 1'b0, 3'b000, 1},
            '{LDI, 2'd2, 2'd0, 2'd0, 8'h0B, 8'h0B, 1'b0, 3'b000, 1},
            '{MUL, 2'd3, 2'd1, 2'd2, 8'h00, 8'h8F, 1'b0, 3'b010, 9},
            '{LDI, 2'd0, 2'd0, 2'd0, 8'h10, 8'h10, 1'b0, 3'b000, 1},
            '{MUL, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 3'b100, 9},
            '{LDI, 2'd1, 2'd0, 2'd0, 8'h42, 8'h42, 1'b0, 3'b000, 1},
            '{LDI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 3'b100, 1},
            '{RSV, 2'd1, 2'd0, 2'd0, 8'h55, 8'h00, 1'b1, 3'b100, 1},
            '{ADD, 2'd2, 2'd1, 2'd0, 8'h00, 8'h42, 1'b0, 3'b000, 2},
            '{ADD, 2'd1, 2'd1, 2'd1, 8'h00, 8'h84, 1'b0, 3'b011, 2},
            '{ADD, 2'd0, 2'd1, 2'd0, 8'h00, 8'h84, 1'b0, 3'b010, 2},
            '{BSA, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 3'b100, 2}
        };

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_op", int'(alu_op), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);

        // MUL aborted by reset: no writeback, no response, RF cleared
        run("pre_ldi1", '{LDI, 2'd1, 2'd0, 2'd0, 8'h8D, 8'h8D, 1'b0, 3'b010, 1});
        run("pre_ldi2", '{LDI, 2'd2, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 3'b010, 1});
        @(negedge clk);
        drive(MUL, 2'd3, 2'd1, 2'd2, 8'h00);
        @(posedge clk);
        sb.push_back('{8'h00, 1'b0, 3'b000, 9});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mul_alu_b", int'(alu_b), 8'h8D);
        check("mul_alu_op", int'(alu_op), 0);
        check("mul_busy", int'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_flags", int'(flags), 0);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        check("abort_no_rsp", int'(rsp_valid), 0);
        run("rf_clr_r0", '{ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 3'b100, 2});
        run("rf_clr_r12", '{ADD, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 3'b100, 2});

        for (int i = 0; i < 20; i++) run($sformatf("v%0d", i), tbl[i]);

        // Backpressure: response held, commands ignored, commit only on handshake
        run("bp_ldi0", '{LDI, 2'd0, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 3'b000, 1});
        run("bp_ldi1", '{LDI, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 3'b010, 1});
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(ADD, 2'd2, 2'd0, 2'd1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(LDI, 2'd0, 2'd0, 2'd0, 8'h99);
        wait_rsp(n);
        check("bp_latency", n, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", k), int'(rsp_valid), 1);
            check($sformatf("bp_hold_data%0d", k), int'(rsp_data), 8'h00);
            check($sformatf("bp_hold_ready%0d", k), int'(cmd_ready), 0);
            check($sformatf("bp_hold_flags%0d", k), int'(flags), 3'b010);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_flags", int'(flags), 3'b100);
        check("bp_rsp_drop", int'(rsp_valid), 0);
        check("bp_cmd_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        check("bp_no_accept", int'(rsp_valid), 0);
        run("bp_readback", '{ADD, 2'd3, 2'd0, 2'd2, 8'h00, 8'h01, 1'b0, 3'b000, 2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Command-driven execution stage that sits directly upstream of the 8-bit ALU (AluOp[3:0], A, B in; Result, Zero, Negative, Overflow out).
- Accepts register-addressed commands over a valid/ready handshake and reads operands from a 4x8 register file.
- Drives the combinational ALU, registers its result and flags, and writes the result back.
- Adds a multi-cycle 8x8 shift-add multiply (low byte) built from repeated ALU adds, and a load-immediate.

Parameters:
- NREGS, 4, number of register-file entries (index width = 2; fixed for this revision)
- MUL_STEPS, 8, shift-add iterations for MUL; equals the data width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  stage can accept a command
- cmd_op  input  5  bit4=0: AluOp=cmd_op[3:0]; 5'b10000 MUL; 5'b10001 LDI; other bit4=1 codes reserved
- cmd_rd  input  2  destination register
- cmd_rs1  input  2  source 1 (ALU A / multiplicand)
- cmd_rs2  input  2  source 2 (ALU B / multiplier)
- cmd_imm  input  8  immediate for LDI
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_op  output  4  to ALU AluOp
- alu_result  input  8  from ALU Result
- alu_zero  input  1  from ALU Zero
- alu_neg  input  1  from ALU Negative
- alu_ovf  input  1  from ALU Overflow
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  result value
- rsp_err  output  1  reserved opcode flag
- flags  output  3  architectural {Z,N,V}, updated on committed ops

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all register-file entries=0; flags=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0; cmd_ready=1 after reset release.
  - alu_a=alu_b=0, alu_op=0.
  - Reset asserted mid-operation aborts the operation: no writeback, no response.
- State machine IDLE, EXEC, MUL, RESP; binary encoded.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/rd/rs1/rs2/imm.
  - Go to EXEC if bit4=0. Go to MUL for 10000 and initialise: acc=0, mcand=RF[rs1], mplier=RF[rs2], cnt=8.
  - LDI: res=imm, Z=(imm==0), N=imm[7], V=0; go to RESP.
  - Reserved op: err=1; go to RESP.
- EXEC (1 cycle):
  - alu_a=RF[rs1], alu_b=RF[rs2], alu_op=op[3:0].
  - Capture res=alu_result and {Z,N,V}={alu_zero,alu_neg,alu_ovf}; go to RESP.
  - AluOp codes that the ALU returns 0 for are passed through unchanged; the stage does no decoding.
- MUL (exactly 8 cycles):
  - Each cycle drive alu_a=acc, alu_b=mcand, alu_op=4'b0000.
  - If mplier[0]=1, acc<=alu_result.
  - Every cycle: mcand<<=1 (zero fill), mplier>>=1 (zero fill), cnt--.
  - On cnt reaching 0, res=acc (mod 256), Z=(res==0), N=res[7], V=0; go to RESP.
- alu_a/alu_b/alu_op are 0 outside EXEC/MUL.
- RESP:
  - rsp_valid=1, rsp_data=res, rsp_err=err; these stay stable until rsp_ready.
  - cmd_ready=0.
  - On rsp_ready: if err=0, RF[rd]<=res and flags<={Z,N,V}; if err=1, no write and flags unchanged. Go to IDLE.
  - No command is accepted in the handshake cycle itself.
- Latency, with the accept edge at cycle T and rsp_ready held high:
  - LDI/reserved: rsp_valid at T+1.
  - ALU ops: rsp_valid at T+2.
  - MUL: rsp_valid at T+9.
- Throughput: the stage is strictly sequential, one command in flight. rd equal to rs1 or rs2 is legal, because operands are read before writeback.
- Arithmetic wraps modulo 256.

Decomposition:
- Shared package:
  - opcode constants OP_MUL=5'b10000 and OP_LDI=5'b10001.
  - ALU op constants for ADD=4'b0000.
  - state encoding.
  - DATA_W=8.
- One sub-module, alu_regfile_4x8:
  - two asynchronous read ports and one synchronous write port.
  - async active-low reset clears all entries.

Test Plan:
- Reset: rst_n low 3 cycles mid-MUL -> rsp_valid=0, flags=0, cmd_ready=1 after release, RF all 0 (check via ADD r0+r0 -> rsp_data=0x00, Z=1).
- LDI r1=10, LDI r2=5, op 00000 rd=r3 rs1=r1 rs2=r2 -> rsp_data=0x0F at T+2, flags Z=0 N=0 V=0; op 00001 (B-A) -> 0xFB, N=1.
- LDI r0=127, r1=1, ADD rd=r2 -> 0x80, flags N=1 V=1; then EQ (00101) r2,r2 -> 0x01, Z=0 N=0 V=0.
- MUL r1=13, r2=11 -> rsp_data=0x8F at T+9, N=1 V=0; MUL 0x10 by 0x10 -> 0x00, Z=1.
- Backpressure: rsp_ready low for 3 cycles after rsp_valid -> rsp_valid/rsp_data held stable, cmd_ready=0, cmd_valid ignored, RF and flags unchanged until the handshake cycle.
- Reserved op 5'b10010 rd=r1 -> rsp_valid at T+1 with rsp_err=1; r1 and flags unchanged (read back r1).
